muldiv_unit: RTL
================

# muldiv_unit

Iterative RV32M/RV64M multiply–divide unit for the EX stage, the multi-cycle successor of the ALU controller's single-cycle operation decode. It takes the M-extension funct3 plus two operands, runs a radix-2 shift-add multiply or restoring divide over WIDTH cycles, and returns a WIDTH-bit result. While it works, `busy` stalls the pipeline. Divide-by-zero and signed overflow complete on a fast path.

## Interface
- WIDTH, 32: operand/result width (32 or 64)
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  request; accepted only in IDLE or DONE
- funct3  in  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- op_a  in  WIDTH  rs1 operand (multiplicand / dividend)
- op_b  in  WIDTH  rs2 operand (multiplier / divisor)
- flush  in  1  abort the current operation (branch mispredict / trap)
- busy  out  1  high in CALC and FIX; EX stall request
- done  out  1  one-cycle pulse; result valid
- result  out  WIDTH  held from done until the next accepted start

## Operation
- States: IDLE, CALC, FIX, DONE. Reset forces IDLE, busy=0, done=0, result=0, counter=0, internal registers 0.
- IDLE/DONE + start: latch the op, take operand magnitudes and record the signs:
  - signed ops: DIV, REM, MULH, and op_a only for MULHSU.
  - Normal ops go to CALC with counter=0.
- Fast path, decided at accept and going straight to DONE:
  - divisor==0: quotient = all ones, remainder = op_a.
  - signed DIV/REM with op_a = most-negative value and op_b = −1: quotient = op_a, remainder = 0.
- CALC, one iteration per cycle, WIDTH iterations total; counter is $clog2(WIDTH)+1 bits.
  - MUL*: 2·WIDTH product register. If the multiplier LSB is 1, add the multiplicand to the upper half. Then shift right 1, keeping the carry.
  - DIV*: shift the {rem,quot} pair left 1. Trial-subtract the divisor from rem. If the result is non-negative, commit it and set the quot LSB.
- FIX, one cycle:
  - Negate the product when the operand signs differ.
  - Quotient is negative when the signs differ. Remainder takes the sign of the dividend.
  - Select MUL = low half, MULH* = high half, DIV* = quotient, REM* = remainder.
  - Register the selection into result.
- DONE: done=1 for exactly one cycle.
  - With start: accept back-to-back and go to CALC, or to DONE on the fast path.
  - Without start: go to IDLE.
- start while busy: ignored, no state change.
- flush: highest priority after reset. Any state goes to IDLE on the next edge. No done pulse. result unchanged. A start in the same cycle is ignored.
- Reset mid-operation: immediate return to the reset values, regardless of clk.

## Timing
- start is sampled at edge E0.
- Normal op: busy high from E0 through E(WIDTH+1). done and the new result are visible after E(WIDTH+2), which is latency WIDTH+2. busy is 0 in the done cycle.
- Fast path: done and result are visible after E1. busy never rises.
- result updates only at the FIX→DONE edge or the fast-path accept edge.
- All outputs are registered. No combinational path from inputs to outputs.

## Structure
- `muldiv_pkg` holds:
  - the state enum (`muldiv_state_e`)
  - funct3 localparams (`F3_MUL` … `F3_REMU`)
  - helper functions `is_signed_a`/`is_signed_b`
- The package is shared with the decoder, which asserts start on funct7 = 0000001.
- Single module; no sub-module. The datapath (one WIDTH+1-bit adder/subtractor, product/rem-quot shift registers) is shared between multiply and divide.

## Test plan (WIDTH=32)
- MUL 7 × 0xFFFFFFFD (−3) → result 0xFFFFFFEB, done exactly 34 cycles after start, busy high 34 cycles.
- MULH 0x80000000×0x80000000 → 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD; REM same operands → 0xFFFFFFFF; DIVU 100/7 → 14; REMU → 2.
- DIVU 5/0 → 0xFFFFFFFF and REM 5/0 → 5, each with done 1 cycle after start and busy never high; DIV 0x80000000/0xFFFFFFFF → 0x80000000, REM → 0, also fast.
- Start MUL, flush at cycle 10 → busy low at cycle 11, no done, result keeps the previous value. A start pulse at cycle 5 of the op is ignored.
- Back-to-back: start held high in the DONE cycle → second op accepted with no IDLE gap. Reset asserted mid-CALC → busy/done/result 0 immediately; next op completes correctly.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the M-extension multiply/divide unit and the decoder that feeds it.
package muldiv_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } muldiv_state_e;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   // rs1 is treated as signed for MULHSU too; rs2 only for the fully signed ops.
   function automatic logic is_signed_a(input logic [2:0] f3);
      return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
   endfunction

   function automatic logic is_signed_b(input logic [2:0] f3);
      return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
   endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply / restoring divide for RV32M/RV64M; one shared
// adder and one double-width shift register serve both operation classes.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       funct3,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   muldiv_state_e      state;
   logic [CW-1:0]      counter;
   logic [2:0]         op;
   logic               neg_a;
   logic               neg_b;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   operand;

   logic               accept;
   logic               in_neg_a;
   logic               in_neg_b;
   logic [WIDTH-1:0]   mag_a;
   logic [WIDTH-1:0]   mag_b;
   logic               div_zero;
   logic               div_ovf;
   logic [WIDTH-1:0]   fast_result;

   // Operand conditioning at accept: magnitudes, signs and fast-path detection.
   assign accept   = start && ((state == ST_IDLE) || (state == ST_DONE));
   assign in_neg_a = is_signed_a(funct3) && op_a[WIDTH-1];
   assign in_neg_b = is_signed_b(funct3) && op_b[WIDTH-1];
   assign mag_a    = in_neg_a ? (~op_a + 1'b1) : op_a;
   assign mag_b    = in_neg_b ? (~op_b + 1'b1) : op_b;
   assign div_zero = funct3[2] && (op_b == '0);
   assign div_ovf  = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                     (op_a == MOST_NEG) && (op_b == '1);
   assign fast_result = div_zero ? (funct3[1] ? op_a : '1)
                                 : (funct3[1] ? '0   : op_a);

   logic               is_div;
   logic [WIDTH:0]     add_lhs;
   logic [WIDTH:0]     add_rhs;
   logic [WIDTH:0]     add_sum;
   logic [2*WIDTH-1:0] acc_next;

   // Shared WIDTH+1-bit adder: adds the multiplicand for multiply, subtracts the
   // divisor from the left-shifted partial remainder for divide.
   assign is_div  = op[2];
   assign add_lhs = is_div ? acc[2*WIDTH-1:WIDTH-1] : {1'b0, acc[2*WIDTH-1:WIDTH]};
   assign add_rhs = is_div ? ~{1'b0, operand} : {1'b0, operand};
   assign add_sum = add_lhs + add_rhs + (WIDTH+1)'(is_div);
   assign acc_next = is_div
      ? {(add_sum[WIDTH] ? acc[2*WIDTH-2:WIDTH-1] : add_sum[WIDTH-1:0]),
         acc[WIDTH-2:0], ~add_sum[WIDTH]}
      : {(acc[0] ? add_sum : add_lhs), acc[WIDTH-1:1]};

   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quot_fix;
   logic [WIDTH-1:0]   rem_fix;
   logic [WIDTH-1:0]   fix_result;

   // Sign correction and result selection, registered on the FIX->DONE edge.
   assign prod_fix = (neg_a ^ neg_b) ? (~acc + 1'b1) : acc;
   assign quot_fix = (neg_a ^ neg_b) ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
   assign rem_fix  = neg_a ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];

   always_comb begin
      fix_result = prod_fix[WIDTH-1:0];
      case (op)
         F3_MUL:                       fix_result = prod_fix[WIDTH-1:0];
         F3_MULH, F3_MULHSU, F3_MULHU: fix_result = prod_fix[2*WIDTH-1:WIDTH];
         F3_DIV, F3_DIVU:              fix_result = quot_fix;
         default:                      fix_result = rem_fix;
      endcase
   end

   // Control FSM; the counter runs 0..WIDTH so CALC spends one extra cycle at
   // the terminal count before handing over to FIX.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= ST_IDLE;
         counter <= '0;
         op      <= '0;
         neg_a   <= 1'b0;
         neg_b   <= 1'b0;
         acc     <= '0;
         operand <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         result  <= '0;
      end else if (flush) begin
         state   <= ST_IDLE;
         counter <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               done <= 1'b0;
               if (accept) begin
                  op      <= funct3;
                  neg_a   <= in_neg_a;
                  neg_b   <= in_neg_b;
                  counter <= '0;
                  if (div_zero || div_ovf) begin
                     result <= fast_result;
                     done   <= 1'b1;
                     busy   <= 1'b0;
                     state  <= ST_DONE;
                  end else begin
                     acc     <= funct3[2] ? {{WIDTH{1'b0}}, mag_a} : {{WIDTH{1'b0}}, mag_b};
                     operand <= funct3[2] ? mag_b : mag_a;
                     busy    <= 1'b1;
                     state   <= ST_CALC;
                  end
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_CALC: begin
               if (counter == CW'(WIDTH)) begin
                  state <= ST_FIX;
               end else begin
                  acc     <= acc_next;
                  counter <= counter + CW'(1);
               end
            end
            ST_FIX: begin
               result <= fix_result;
               done   <= 1'b1;
               busy   <= 1'b0;
               state  <= ST_DONE;
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule
